// File: rtl/alu_seq_n_bits.sv
`timescale 1ns/1ps
// Registered, handshaked N-bit ALU: single-cycle logic/arith ops, shift-add
// multiplier and restoring divider, with flags and error held between ops.
module alu_seq_n_bits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_MOD = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam int             CW        = $clog2(N + 1);
  localparam logic [CW-1:0]  ITER_LAST = CW'(N);
  localparam logic [N:0]     N_WIDE    = (N + 1)'(N);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [2*N-1:0]  p_q;
  logic [CW-1:0]   cnt;

  logic            b_zero;
  logic            is_sub;
  logic [N-1:0]    b_eff;
  logic [N:0]      sum;
  logic [N:0]      m_sum;
  logic [N:0]      d_shift;
  logic [N:0]      d_diff;
  logic            shift_oob;

  logic [N-1:0]    fin_res;
  logic [N-1:0]    fin_hi;
  logic            fin_c;
  logic            fin_v;
  logic            fin_err;

  // p_q doubles as {acc, multiplier} for MUL and {remainder, quotient} for DIV/MOD
  always_comb begin
    b_zero    = (b_q == '0);
    is_sub    = (op_q == OP_SUB);
    b_eff     = is_sub ? ~b_q : b_q;
    sum       = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    m_sum     = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, a_q} : '0);
    d_shift   = p_q[2*N-1:N-1];
    d_diff    = d_shift - {1'b0, b_q};
    shift_oob = ({1'b0, b_q} >= N_WIDE);
  end

  always_comb begin
    fin_res = '0;
    fin_hi  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_err = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_res = sum[N-1:0];
        fin_c   = sum[N];
        fin_v   = (a_q[N-1] == b_eff[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_XOR: fin_res = a_q ^ b_q;
      OP_LSR: fin_res = shift_oob ? '0 : (a_q >> b_q);
      OP_LSL: fin_res = shift_oob ? '0 : (a_q << b_q);
      OP_MOD: begin
        fin_res = b_zero ? a_q : p_q[2*N-1:N];
        fin_err = b_zero;
      end
      OP_MUL: begin
        fin_res = p_q[N-1:0];
        fin_hi  = p_q[2*N-1:N];
        fin_c   = |p_q[2*N-1:N];
        fin_v   = |p_q[2*N-1:N];
      end
      OP_DIV: begin
        fin_res = b_zero ? '1 : p_q[N-1:0];
        fin_err = b_zero;
      end
      default: fin_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      v         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= control;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            busy <= 1'b1;
            case (control)
              OP_MUL: begin
                p_q   <= {{N{1'b0}}, b};
                state <= S_MUL;
              end
              OP_MOD, OP_DIV: begin
                p_q   <= {{N{1'b0}}, a};
                state <= S_DIV;
              end
              default: begin
                p_q   <= '0;
                state <= S_EXEC;
              end
            endcase
          end
        end
        S_EXEC: state <= S_DONE;
        S_MUL: begin
          if (cnt == ITER_LAST) begin
            state <= S_DONE;
          end else begin
            p_q <= {m_sum, p_q[N-1:1]};
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (b_zero || cnt == ITER_LAST) begin
            state <= S_DONE;
          end else begin
            p_q <= d_diff[N] ? {d_shift[N-1:0], p_q[N-2:0], 1'b0}
                             : {d_diff[N-1:0],  p_q[N-2:0], 1'b1};
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          result    <= fin_res;
          result_hi <= fin_hi;
          v         <= fin_v;
          c         <= fin_c;
          n         <= fin_res[N-1];
          z         <= (fin_res == '0);
          err       <= fin_err;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n_bits.sv
`timescale 1ns/1ps
// Bench for alu_seq_n_bits: directed and random ops on N=4 against an
// arithmetic reference, plus back-to-back DIV with start held high on N=8.
module tb_alu_seq_n_bits;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       start4, busy4, done4, v4, c4, n4, z4, err4;
  logic [3:0] a4, b4, ctl4, res4, hi4;

  logic       start8, busy8, done8, v8, c8, n8, z8, err8;
  logic [7:0] a8, b8, res8, hi8;
  logic [3:0] ctl8;

  int n_asserts = 0;
  int n_fail    = 0;

  alu_seq_n_bits #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .control(ctl4),
    .busy(busy4), .done(done4), .result(res4), .result_hi(hi4),
    .v(v4), .c(c4), .n(n4), .z(z4), .err(err4)
  );

  alu_seq_n_bits #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .control(ctl8),
    .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
    .v(v8), .c(c8), .n(n8), .z(z8), .err(err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sgn(input longint x, input int w);
    return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
  endfunction

  // Reference: plain integer arithmetic on operand values, two's-complement
  // overflow judged by whether the signed result leaves the w-bit range.
  function automatic void model(input int w, input int op, input longint a, input longint b,
                                output longint r, output longint hi,
                                output logic v, output logic c, output logic e,
                                output int lat);
    longint m, s, lo_lim, hi_lim;
    m = (longint'(1) << w) - 1;
    lo_lim = -(longint'(1) << (w - 1));
    hi_lim = (longint'(1) << (w - 1)) - 1;
    r = 0; hi = 0; v = 0; c = 0; e = 0; lat = 2;
    case (op)
      0: begin
        s = a + b; r = s & m; c = (s > m);
        s = sgn(a, w) + sgn(b, w); v = (s < lo_lim) || (s > hi_lim);
      end
      1: begin
        r = (a - b) & m; c = (a >= b);
        s = sgn(a, w) - sgn(b, w); v = (s < lo_lim) || (s > hi_lim);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= w) ? 0 : (a >> b);
      6: r = (b >= w) ? 0 : ((a << b) & m);
      7: if (b == 0) begin r = a; e = 1; end else begin r = a % b; lat = w + 2; end
      8: begin s = a * b; r = s & m; hi = s >> w; c = (hi != 0); v = c; lat = w + 2; end
      9: if (b == 0) begin r = m; e = 1; end else begin r = a / b; lat = w + 2; end
      default: e = 1;
    endcase
  endfunction

  task automatic run4(input int op, input int av, input int bv);
    longint er, eh;
    logic ev, ec, ee;
    int lat, k;
    bit seen;
    model(4, op, longint'(av), longint'(bv), er, eh, ev, ec, ee, lat);
    @(negedge clk);
    start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; ctl4 = op[3:0];
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("accept_busy", 64'(busy4), 64'(1));
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done4) seen = 1;
      else begin a4 = 4'($urandom); b4 = 4'($urandom); ctl4 = 4'($urandom); end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(k), 64'(lat));
    chk("result", 64'(res4), 64'(er));
    chk("result_hi", 64'(hi4), 64'(eh));
    chk("flags_vcnze", 64'({v4, c4, n4, z4, err4}), 64'({ev, ec, er[3], er == 0, ee}));
    chk("busy_at_done", 64'(busy4), 64'(0));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done4), 64'(0));
    chk("result_held", 64'(res4), 64'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit seen, got;
    int av8[3], bv8[3];

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; ctl4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; ctl8 = '0;
    #12;
    chk("reset_busy4", 64'(busy4), 64'(0));
    chk("reset_outs4", 64'({done4, res4, hi4, v4, c4, n4, z4, err4}), 64'(0));
    chk("reset_outs8", 64'({busy8, done8, res8, hi8, v8, c8, n8, z8, err8}), 64'(0));
    @(negedge clk); rst = 1'b0;

    run4(0, 7, 1);

    // Reset two cycles into a MUL: outputs clear at once, no done afterwards
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd3; ctl4 = 4'd8;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrst_busy", 64'(busy4), 64'(0));
    chk("midrst_outs", 64'({done4, res4, hi4, v4, c4, n4, z4, err4}), 64'(0));
    @(negedge clk); rst = 1'b0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) got = 1;
    end
    chk("midrst_no_done", 64'(got), 64'(0));

    run4(8, 7, 3);
    run4(1, 3, 3);
    run4(8, 15, 15);
    run4(9, 13, 4);
    run4(7, 13, 4);
    run4(9, 9, 0);
    run4(7, 9, 0);
    run4(6, 3, 5);
    run4(5, 12, 4);
    run4(12, 5, 5);
    run4(2, 12, 10);
    run4(1, 8, 1);
    for (int i = 0; i < 40; i++)
      run4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

    // N=8: start held high across three DIVs, operands scrambled while busy
    for (int i = 0; i < 3; i++) begin
      av8[i] = int'($urandom_range(0, 255));
      bv8[i] = int'($urandom_range(1, 255));
    end
    @(negedge clk);
    start8 = 1'b1; ctl8 = 4'd9; a8 = av8[0][7:0]; b8 = bv8[0][7:0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b_accept_busy", 64'(busy8), 64'(1));
      chk("b2b_no_done_at_accept", 64'(done8), 64'(0));
      k = 0; seen = 0;
      while (!seen && k < 40) begin
        @(posedge clk); #1;
        k++;
        if (done8) seen = 1;
        else begin a8 = 8'($urandom); b8 = 8'($urandom); end
      end
      chk("b2b_done_seen", 64'(seen), 64'(1));
      chk("b2b_latency", 64'(k), 64'(10));
      chk("b2b_quotient", 64'(res8), 64'(av8[i] / bv8[i]));
      chk("b2b_err", 64'(err8), 64'(0));
      if (i < 2) begin a8 = av8[i+1][7:0]; b8 = bv8[i+1][7:0]; end
      else start8 = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_idle_after", 64'({busy8, done8}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
